fb_line_fetch: RTL and testbench

Framebuffer scan-line prefetcher that sits directly upstream of the 640x480 LCD timing generator. It follows the generator's `x`/`y` pixel coordinates and returns 6:6:6 RGB for the generator's `red`/`green`/`blue` inputs. Pixels are read from an external byte-wide RGB332 frame memory through a req/ack handshake into a ping-pong pair of line buffers. Line `y+1` is always fetched while line `y` is being displayed.

---
 rtl/fb_pkg.sv | 26 ++
 rtl/fb_line_fetch_line_ram.sv | 20 ++
 rtl/fb_line_fetch.sv | 114 +++++++++++
 tb/tb_fb_line_fetch.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared constants, RGB332 field layout, colour expansion and FSM states
// for the framebuffer scan-line prefetcher.
package fb_pkg;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;
    typedef enum logic {IDLE, FETCH} state_t;
    typedef struct packed {
        logic [5:0] r;
        logic [5:0] g;
        logic [5:0] b;
    } rgb666_t;
    // Replicate each field so full-scale RGB332 maps to full-scale 6:6:6.
    function automatic rgb666_t rgb332_to_666(input logic [7:0] p);
        rgb666_t c;
        c.r = {2{p[R_MSB:R_LSB]}};
        c.g = {2{p[G_MSB:G_LSB]}};
        c.b = {3{p[B_MSB:B_LSB]}};
        return c;
    endfunction
endpackage

// File: rtl/fb_line_fetch_line_ram.sv
// line_ram: ping-pong line store, one write port and one registered read port.
// Ports: clk; we/wbuf/widx/wdata write side; rbuf/ridx read address; rdata one cycle later.
module line_ram #(
    parameter int DEPTH = 640
) (
    input  logic       clk,
    input  logic       we,
    input  logic       wbuf,
    input  logic [9:0] widx,
    input  logic [7:0] wdata,
    input  logic       rbuf,
    input  logic [9:0] ridx,
    output logic [7:0] rdata
);
    logic [7:0] mem [2][DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[wbuf][widx] <= wdata;
        rdata <= mem[rbuf][ridx];
    end
endmodule

// File: rtl/fb_line_fetch.sv
// fb_line_fetch: prefetches line y+1 from byte-wide RGB332 memory into a ping-pong
// line buffer while line y is displayed, and returns 6:6:6 colour for (x, y).
// Ports: CLOCK_50/rst_n; x/y display coordinate; red/green/blue colour (2-cycle latency);
// mem_req/mem_addr/mem_ack/mem_data fetch handshake; fetch_busy; underrun (sticky).
module fb_line_fetch
    import fb_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ADDR_W = 19,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic [9:0]        x,
    input  logic [8:0]        y,
    output logic [5:0]        red,
    output logic [5:0]        green,
    output logic [5:0]        blue,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic              fetch_busy,
    output logic              underrun
);
    state_t            state;
    logic              prime;
    logic [9:0]        idx;
    logic [8:0]        fl;
    logic [8:0]        y_d;
    logic [8:0]        nl;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] step_base;
    logic [ADDR_W-1:0] nb;
    logic              chg;
    logic              ack;
    logic              last;
    logic              in_d;
    logic [7:0]        ram_q;

    assign chg        = y != y_d;
    assign nl         = (y == 9'(V_ACTIVE - 1)) ? '0 : y + 9'd1;
    // Line bases advance by one line per change; wrapping to line 0 reloads the base.
    assign step_base  = line_base + ADDR_W'(H_ACTIVE);
    assign nb         = (nl == '0) ? BASE_ADDR : step_base;
    assign mem_req    = state == FETCH;
    assign fetch_busy = mem_req;
    assign ack        = mem_req && mem_ack;
    assign last       = idx == 10'(H_ACTIVE - 1);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prime     <= 1'b1;
            idx       <= '0;
            fl        <= '0;
            y_d       <= '0;
            line_base <= '0;
            mem_addr  <= '0;
            underrun  <= 1'b0;
        end else begin
            y_d <= y;
            if (chg) begin
                // A line change always wins, including over a final ack in the same cycle.
                underrun  <= underrun | mem_req;
                state     <= FETCH;
                prime     <= 1'b0;
                idx       <= '0;
                fl        <= nl;
                line_base <= nb;
                mem_addr  <= nb;
            end else if (state == IDLE && prime) begin
                state     <= FETCH;
                idx       <= '0;
                fl        <= '0;
                line_base <= BASE_ADDR;
                mem_addr  <= BASE_ADDR;
            end else if (ack && last && prime && fl == '0) begin
                idx       <= '0;
                fl        <= 9'd1;
                line_base <= step_base;
                mem_addr  <= step_base;
            end else if (ack && last) begin
                state <= IDLE;
                prime <= 1'b0;
            end else if (ack) begin
                idx      <= idx + 10'd1;
                mem_addr <= mem_addr + 1'b1;
            end
        end
    end

    line_ram #(.DEPTH(H_ACTIVE)) u_ram (
        .clk   (CLOCK_50),
        .we    (ack && !chg),
        .wbuf  (fl[0]),
        .widx  (idx),
        .wdata (mem_data),
        .rbuf  (y[0]),
        .ridx  (x),
        .rdata (ram_q)
    );

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            in_d                <= 1'b0;
            {red, green, blue}  <= '0;
        end else begin
            in_d                <= x < 10'(H_ACTIVE);
            {red, green, blue}  <= in_d ? rgb332_to_666(ram_q) : '0;
        end
    end
endmodule

// File: tb/tb_fb_line_fetch.sv
// tb_fb_line_fetch: scoreboard bench; memory responder checks fetch addresses, pixel monitor checks colour.
module tb_fb_line_fetch;
    localparam logic [18:0] BASE = 19'h7FF00;
    localparam logic [17:0] P1B  = 18'b000000_110110_111111;

    logic        clk;
    logic        rst_n;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [5:0]  red, green, blue;
    logic        mem_req;
    logic [18:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic        fetch_busy;
    logic        underrun;
    logic        corrupt;
    logic        chk_mem;

    typedef struct {int due; logic [17:0] e;} pexp_t;
    logic [18:0] exp_q[$];
    pexp_t       pix_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_ack = 0;
    int ack_mode = 0;

    function automatic logic [7:0] mbyte(input logic [18:0] off);
        return off[7:0] ^ off[15:8] ^ 8'h1E;
    endfunction

    function automatic logic [18:0] laddr(input int l, input int p);
        return 19'(int'(BASE) + l * 640 + p);
    endfunction

    function automatic logic [17:0] epix(input int l, input int p);
        logic [7:0] b;
        if (p >= 640) return '0;
        b = mbyte(19'(l * 640 + p));
        return {b[7:5], b[7:5], b[4:2], b[4:2], b[1:0], b[1:0], b[1:0]};
    endfunction

    assign mem_data = mbyte(mem_addr - BASE) ^ (corrupt ? 8'hFF : 8'h00);

    fb_line_fetch #(.BASE_ADDR(BASE)) dut (
        .CLOCK_50   (clk),
        .rst_n      (rst_n),
        .x          (x),
        .y          (y),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .fetch_busy (fetch_busy),
        .underrun   (underrun)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic push_line(input int l);
        for (int p = 0; p < 640; p++) exp_q.push_back(laddr(l, p));
    endtask

    task automatic pix(input int px, input int py, input logic [17:0] e);
        x = 10'(px);
        y = 9'(py);
        pix_q.push_back('{cyc + 2, e});
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (fetch_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(fetch_busy), 0);
    endtask

    initial begin
        int rc;
        logic [18:0] e;
        rc = 0;
        mem_ack = 0;
        forever begin
            @(negedge clk);
            #1;
            rc++;
            mem_ack = (ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? (rc % 3 == 0) : 1'b0;
            if (mem_ack && mem_req) begin
                n_ack++;
                if (chk_mem) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mem_addr: unexpected ack at %0h, none expected", mem_addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("mem_addr", 32'(mem_addr), 32'(e));
                    end
                end
            end
        end
    end

    initial begin
        pexp_t p;
        forever begin
            @(negedge clk);
            if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
                p = pix_q.pop_front();
                chk("pixel", 32'({red, green, blue}), 32'(p.e));
            end
        end
    end

    initial begin
        logic [18:0] a0;
        int n0;
        rst_n = 0; x = 0; y = 0; corrupt = 0; chk_mem = 1;
        repeat (3) @(negedge clk);
        chk("rst_rgb", 32'({red, green, blue}), 0);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_busy", 32'(fetch_busy), 0);
        chk("rst_underrun", 32'(underrun), 0);
        push_line(0);
        push_line(1);
        rst_n = 1;
        wait_idle(1400);
        chk("prime_acks", 32'(n_ack), 1280);
        chk("prime_queue", 32'(exp_q.size()), 0);
        chk("prime_underrun", 32'(underrun), 0);
        repeat (5) @(negedge clk);
        chk("prime_stop", 32'(n_ack), 1280);

        pix(5, 0, P1B);
        pix(0, 0, epix(0, 0));
        pix(639, 0, epix(0, 639));
        pix(700, 0, '0);
        pix(1023, 0, '0);
        push_line(2);
        pix(5, 1, epix(1, 5));
        pix(256, 1, epix(1, 256));
        pix(639, 1, epix(1, 639));
        wait_idle(800);
        chk("line2_queue", 32'(exp_q.size()), 0);

        ack_mode = 2;
        push_line(3);
        y = 2;
        @(negedge clk);
        a0 = mem_addr;
        n0 = n_ack;
        chk("hold_base", 32'(a0), 32'h00680);
        chk("hold_busy", 32'(fetch_busy), 1);
        repeat (10) begin
            @(negedge clk);
            chk("hold_req", 32'(mem_req), 1);
            chk("hold_addr", 32'(mem_addr), 32'(a0));
        end
        chk("hold_noack", 32'(n_ack), 32'(n0));
        ack_mode = 0;
        wait_idle(800);
        chk("line3_queue", 32'(exp_q.size()), 0);
        chk("line3_underrun", 32'(underrun), 0);

        corrupt = 1;
        repeat (6) @(negedge clk);
        corrupt = 0;
        push_line(4);
        pix(0, 3, epix(3, 0));
        pix(639, 3, epix(3, 639));
        wait_idle(800);

        chk_mem = 0;
        ack_mode = 1;
        y = 4;
        repeat (1599) @(negedge clk);
        chk("slow_pre_underrun", 32'(underrun), 0);
        chk("slow_busy", 32'(fetch_busy), 1);
        y = 5;
        @(negedge clk);
        chk("abort_underrun", 32'(underrun), 1);
        chk("abort_restart", 32'(mem_addr), 32'h00E00);
        chk("abort_req", 32'(mem_req), 1);
        push_line(6);
        chk_mem = 1;
        ack_mode = 0;
        wait_idle(800);
        chk("line6_queue", 32'(exp_q.size()), 0);
        chk("line6_underrun", 32'(underrun), 1);
        push_line(7);
        y = 6;
        wait_idle(800);
        chk("line7_queue", 32'(exp_q.size()), 0);
        chk("sticky_underrun", 32'(underrun), 1);

        chk_mem = 0;
        for (int v = 7; v <= 478; v++) begin
            y = 9'(v);
            repeat (2) @(negedge clk);
        end
        wait_idle(800);
        chk_mem = 1;
        push_line(0);
        y = 479;
        wait_idle(800);
        chk("wrap_queue", 32'(exp_q.size()), 0);
        push_line(1);
        pix(5, 0, P1B);
        pix(300, 0, epix(0, 300));
        wait_idle(800);
        chk("wrap_line1_queue", 32'(exp_q.size()), 0);

        chk_mem = 0;
        y = 1;
        repeat (301) @(negedge clk);
        chk("mid_req", 32'(mem_req), 1);
        #2 rst_n = 0;
        #1;
        chk("async_req", 32'(mem_req), 0);
        chk("async_addr", 32'(mem_addr), 0);
        chk("async_busy", 32'(fetch_busy), 0);
        chk("async_underrun", 32'(underrun), 0);
        @(negedge clk);
        y = 0;
        push_line(0);
        push_line(1);
        chk_mem = 1;
        n0 = n_ack;
        @(negedge clk);
        rst_n = 1;
        wait_idle(1400);
        chk("reprime_acks", 32'(n_ack - n0), 1280);
        chk("reprime_queue", 32'(exp_q.size()), 0);
        chk("reprime_underrun", 32'(underrun), 0);
        pix(5, 0, P1B);
        repeat (3) @(negedge clk);
        chk("pix_queue", 32'(pix_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
